// File: rtl/fifo_wr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_pkg
// Shared definitions for the FIFO write-port arbiter:
//   - state_t        : arbiter FSM encoding (IDLE / GRANT)
//   - DEF_DATA_WIDTH : sample width shared with the FIFO and filter datapath
//   - clog2()        : ceiling log2, usable in parameter expressions
// -----------------------------------------------------------------------------
package fifo_wr_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int DEF_DATA_WIDTH = 16;

   // Ceiling log2; returns 0 for values <= 1.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_rr_pick
// Combinational round-robin picker. Returns the first asserted request at or
// after index ptr, wrapping modulo NUM_REQ.
// Ports:
//   req  in  NUM_REQ  request vector
//   ptr  in  PTR_W    index with highest priority this cycle (< NUM_REQ)
//   sel  out NUM_REQ  one-hot winner (all zero when no request)
//   any  out 1        at least one request asserted
// -----------------------------------------------------------------------------
module fifo_wr_arbiter_rr_pick
   import fifo_wr_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] sel,
   output logic               any
);

   logic [NUM_REQ-1:0] w_rot;
   logic [NUM_REQ-1:0] w_rot_sel;

   // Rotate so that index ptr lands on bit 0; the doubled vector makes the
   // shift a rotation.
   assign w_rot     = NUM_REQ'({req, req} >> ptr);
   // Lowest set bit wins (fixed priority on the rotated vector).
   assign w_rot_sel = w_rot & (~w_rot + 1'b1);
   // Rotate the winner back into original index space (upper half of the
   // doubled, left-shifted vector).
   assign sel       = NUM_REQ'(({w_rot_sel, w_rot_sel} << ptr) >> NUM_REQ);
   assign any       = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin write-port arbiter in front of the async FIFO write side.
// Grants one requester at a time for up to BURST_LEN words, forwards its
// words to the FIFO and stalls combinationally on wfull.
// Ports:
//   wclk, wrst_n  write-domain clock, async active-low reset
//   req_valid     in  NUM_REQ             per-requester word valid
//   req_data      in  NUM_REQ*DATA_WIDTH  requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last      in  NUM_REQ             last word of burst (qualified by valid)
//   req_ready     out NUM_REQ             word accepted when valid & ready
//   wfull         in  1                   FIFO full flag
//   winc          out 1                   FIFO write strobe
//   wdata         out DATA_WIDTH          FIFO write data (0 when not writing)
//   grant         out NUM_REQ             one-hot registered owner
//   busy          out 1                   high while in GRANT
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
   import fifo_wr_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int BURST_LEN  = 4
) (
   input  logic                          wclk,
   input  logic                          wrst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          wfull,
   output logic                          winc,
   output logic [DATA_WIDTH-1:0]         wdata,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          busy
);

   localparam int PTR_W  = (clog2(NUM_REQ)   > 1) ? clog2(NUM_REQ)   : 1;
   localparam int BEAT_W = (clog2(BURST_LEN) > 1) ? clog2(BURST_LEN) : 1;

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
   localparam logic [PTR_W-1:0]  LAST_REQ  = PTR_W'(NUM_REQ - 1);

   state_t              r_state;
   state_t              w_next_state;
   logic [NUM_REQ-1:0]  r_grant;
   logic [PTR_W-1:0]    r_gidx;
   logic [PTR_W-1:0]    r_rr_ptr;
   logic [BEAT_W-1:0]   r_beat_cnt;

   logic [NUM_REQ-1:0]  w_pick_sel;
   logic                w_pick_any;
   logic [PTR_W-1:0]    w_pick_idx;
   logic                w_xfer;
   logic                w_release;

   fifo_wr_arbiter_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_pick (
      .req (req_valid),
      .ptr (r_rr_ptr),
      .sel (w_pick_sel),
      .any (w_pick_any)
   );

   // One-hot to index; the index is registered alongside grant so the data
   // mux and pointer update need no encoder on the registered side.
   always_comb begin
      w_pick_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_pick_sel[i]) w_pick_idx = PTR_W'(i);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) r_state <= IDLE;
      else         r_state <= w_next_state;
   end

   // NOTE: every output of this block is given a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      w_next_state = r_state;
      req_ready    = '0;
      w_xfer       = 1'b0;
      w_release    = 1'b0;
      winc         = 1'b0;
      wdata        = '0;
      case (r_state)
         IDLE: begin
            if (w_pick_any) w_next_state = GRANT;
         end
         GRANT: begin
            // Gating is purely combinational on wfull so a write can never
            // be issued in a cycle where the FIFO reports full.
            req_ready[r_gidx] = ~wfull;
            w_xfer            = req_valid[r_gidx] & ~wfull;
            winc              = w_xfer;
            if (w_xfer) wdata = req_data[r_gidx*DATA_WIDTH +: DATA_WIDTH];
            // req_last on the final beat still yields a single release.
            w_release = w_xfer & (req_last[r_gidx] | (r_beat_cnt == LAST_BEAT));
            if (w_release) w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         r_grant    <= '0;
         r_gidx     <= '0;
         r_rr_ptr   <= '0;
         r_beat_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pick_any) begin
                  r_grant    <= w_pick_sel;
                  r_gidx     <= w_pick_idx;
                  r_beat_cnt <= '0;
               end
            end
            GRANT: begin
               if (w_release) begin
                  r_grant    <= '0;
                  r_beat_cnt <= '0;
                  r_rr_ptr   <= (r_gidx == LAST_REQ) ? '0 : r_gidx + 1'b1;
               end else if (w_xfer) begin
                  r_beat_cnt <= r_beat_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign grant = r_grant;
   assign busy  = (r_state == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=16, BURST_LEN=4).
// Requester i presents word {i[3:0], seq[11:0]}; seq advances on each accepted
// word, so every expected write value below is a hand-derived constant.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

   localparam int NR = 4;
   localparam int DW = 16;

   logic          wclk = 1'b0;
   logic          wrst_n;
   logic [NR-1:0] req_valid;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0] req_last;
   logic [NR-1:0] req_ready;
   logic          wfull;
   logic          winc;
   logic [DW-1:0] wdata;
   logic [NR-1:0] grant;
   logic          busy;

   logic [11:0]   seq [NR];
   int            n_cmp = 0;
   int            n_err = 0;

   always #5 wclk = ~wclk;

   fifo_wr_arbiter #(
      .NUM_REQ    (NR),
      .DATA_WIDTH (DW),
      .BURST_LEN  (4)
   ) dut (
      .wclk      (wclk),
      .wrst_n    (wrst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .wfull     (wfull),
      .winc      (winc),
      .wdata     (wdata),
      .grant     (grant),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_data();
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = {4'(i), seq[i]};
   endtask

   // One clock cycle: check outputs at the falling edge, then advance the
   // producers that handed over a word at the rising edge.
   task automatic step(input string tag, input logic e_winc, input logic [15:0] e_wdata,
                       input logic [3:0] e_grant, input logic [3:0] e_ready);
      logic [NR-1:0] acc;
      @(negedge wclk);
      check({tag, ".winc"},  32'(winc),      32'(e_winc));
      check({tag, ".wdata"}, 32'(wdata),     32'(e_wdata));
      check({tag, ".grant"}, 32'(grant),     32'(e_grant));
      check({tag, ".ready"}, 32'(req_ready), 32'(e_ready));
      check({tag, ".busy"},  32'(busy),      32'(|e_grant));
      check({tag, ".nowrfull"}, 32'(winc & wfull), 32'(0));
      acc = req_valid & req_ready;
      @(posedge wclk);
      #1;
      for (int i = 0; i < NR; i++) if (acc[i]) seq[i] = seq[i] + 12'd1;
      drive_data();
   endtask

   task automatic reset_outputs_zero(input string tag);
      check({tag, ".grant"}, 32'(grant),     32'(0));
      check({tag, ".busy"},  32'(busy),      32'(0));
      check({tag, ".winc"},  32'(winc),      32'(0));
      check({tag, ".wdata"}, 32'(wdata),     32'(0));
      check({tag, ".ready"}, 32'(req_ready), 32'(0));
   endtask

   task automatic do_reset(input string tag);
      @(posedge wclk);
      #1;
      wrst_n    = 1'b0;
      req_valid = '0;
      req_last  = '0;
      wfull     = 1'b0;
      for (int i = 0; i < NR; i++) seq[i] = '0;
      drive_data();
      #1;
      reset_outputs_zero(tag);
      @(negedge wclk);
      wrst_n = 1'b1;
      @(posedge wclk);
      #1;
   endtask

   initial begin
      wrst_n    = 1'b0;
      req_valid = '0;
      req_last  = '0;
      wfull     = 1'b0;
      req_data  = '0;
      for (int i = 0; i < NR; i++) seq[i] = '0;

      // ---- reset state
      do_reset("rst0");

      // ---- single requester 2, valid held, no req_last
      req_valid = 4'b0100;
      step("s1_idle",   1'b0, 16'h0000, 4'b0000, 4'b0000);
      step("s1_b0",     1'b1, 16'h2000, 4'b0100, 4'b0100);
      step("s1_b1",     1'b1, 16'h2001, 4'b0100, 4'b0100);
      step("s1_b2",     1'b1, 16'h2002, 4'b0100, 4'b0100);
      step("s1_b3",     1'b1, 16'h2003, 4'b0100, 4'b0100);
      step("s1_bubble", 1'b0, 16'h0000, 4'b0000, 4'b0000);
      step("s1_regrant",1'b1, 16'h2004, 4'b0100, 4'b0100);
      do_reset("rst1");

      // ---- all four requesters valid: order 0,1,2,3 then wrap to 0
      req_valid = 4'b1111;
      step("s2_idle", 1'b0, 16'h0000, 4'b0000, 4'b0000);
      for (int r = 0; r < NR; r++) begin
         for (int b = 0; b < 4; b++) begin
            step($sformatf("s2_r%0d_b%0d", r, b), 1'b1, {4'(r), 12'(b)},
                 4'(1 << r), 4'(1 << r));
         end
         step($sformatf("s2_r%0d_bubble", r), 1'b0, 16'h0000, 4'b0000, 4'b0000);
      end
      step("s2_wrap", 1'b1, 16'h0004, 4'b0001, 4'b0001);
      do_reset("rst2");

      // ---- wfull held high for 5 cycles ahead of beat 2
      req_valid = 4'b0010;
      step("s3_idle", 1'b0, 16'h0000, 4'b0000, 4'b0000);
      step("s3_b0",   1'b1, 16'h1000, 4'b0010, 4'b0010);
      step("s3_b1",   1'b1, 16'h1001, 4'b0010, 4'b0010);
      wfull = 1'b1;
      for (int k = 0; k < 5; k++)
         step($sformatf("s3_full%0d", k), 1'b0, 16'h0000, 4'b0010, 4'b0000);
      wfull = 1'b0;
      step("s3_b2",     1'b1, 16'h1002, 4'b0010, 4'b0010);
      step("s3_b3",     1'b1, 16'h1003, 4'b0010, 4'b0010);
      step("s3_bubble", 1'b0, 16'h0000, 4'b0000, 4'b0000);
      do_reset("rst3");

      // ---- requester 1 ends early with req_last; then 2; then last on beat 3
      req_valid = 4'b0110;
      step("s4_idle", 1'b0, 16'h0000, 4'b0000, 4'b0000);
      step("s4_r1b0", 1'b1, 16'h1000, 4'b0010, 4'b0010);
      req_last = 4'b0010;
      step("s4_r1b1", 1'b1, 16'h1001, 4'b0010, 4'b0010);
      req_last = 4'b0000;
      step("s4_bub1", 1'b0, 16'h0000, 4'b0000, 4'b0000);
      step("s4_r2b0", 1'b1, 16'h2000, 4'b0100, 4'b0100);
      step("s4_r2b1", 1'b1, 16'h2001, 4'b0100, 4'b0100);
      step("s4_r2b2", 1'b1, 16'h2002, 4'b0100, 4'b0100);
      req_last = 4'b0100;
      step("s4_r2b3", 1'b1, 16'h2003, 4'b0100, 4'b0100);
      req_last = 4'b0000;
      step("s4_bub2", 1'b0, 16'h0000, 4'b0000, 4'b0000);
      step("s4_r1again", 1'b1, 16'h1002, 4'b0010, 4'b0010);
      do_reset("rst4");

      // ---- reset asserted mid-burst
      req_valid = 4'b1000;
      step("s5_idle", 1'b0, 16'h0000, 4'b0000, 4'b0000);
      step("s5_b0",   1'b1, 16'h3000, 4'b1000, 4'b1000);
      step("s5_b1",   1'b1, 16'h3001, 4'b1000, 4'b1000);
      #1;
      check("s5_pre.winc", 32'(winc), 32'(1));
      wrst_n = 1'b0;
      #1;
      reset_outputs_zero("s5_async");
      req_valid = 4'b1001;
      @(negedge wclk);
      wrst_n = 1'b1;
      @(posedge wclk);
      #1;
      step("s5_restart", 1'b1, 16'h0000, 4'b0001, 4'b0001);
      do_reset("rst5");

      // ---- requester 0 drops valid mid-burst while 1 waits
      req_valid = 4'b0011;
      step("s6_idle", 1'b0, 16'h0000, 4'b0000, 4'b0000);
      step("s6_b0",   1'b1, 16'h0000, 4'b0001, 4'b0001);
      step("s6_b1",   1'b1, 16'h0001, 4'b0001, 4'b0001);
      req_valid = 4'b0010;
      for (int k = 0; k < 3; k++)
         step($sformatf("s6_gap%0d", k), 1'b0, 16'h0000, 4'b0001, 4'b0001);
      req_valid = 4'b0011;
      step("s6_b2",     1'b1, 16'h0002, 4'b0001, 4'b0001);
      step("s6_b3",     1'b1, 16'h0003, 4'b0001, 4'b0001);
      step("s6_bubble", 1'b0, 16'h0000, 4'b0000, 4'b0000);
      step("s6_r1",     1'b1, 16'h1000, 4'b0010, 4'b0010);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
